// File: rtl/raster_pkg.sv
// Shared definitions for the rasterizer point-collection slice:
// collector state encoding, default grid size and derived widths.
package raster_pkg;

  // Collector frame state
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DUMP    = 2'd2
  } rasterState_e;

  // Default grid dimension (power of two, at least 2)
  localparam int RASTER_N     = 8;
  // Coordinate width for the default grid
  localparam int RASTER_CW    = $clog2(RASTER_N);
  // Point-count width: must hold 0 .. N*N inclusive
  localparam int RASTER_CNT_W = $clog2(RASTER_N * RASTER_N) + 1;

endpackage

// File: rtl/point_bitmap_mem.sv
// N x N occupancy flop array. One set port reports whether the
// addressed bit was already set, one combinational row-read port,
// and a synchronous clear that wipes the whole array.
module point_bitmap_mem #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          setEn_i,
  input  logic [CW-1:0] setX_i,
  input  logic [CW-1:0] setY_i,
  output logic          wasSet_o,
  input  logic [CW-1:0] rdIdx_i,
  output logic [N-1:0]  rdData_o,
  input  logic          clear_i
);

  logic [N-1:0][N-1:0] bits_q;

  // Bit storage: clear wins over set so a frame never leaks into the next
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_q <= '0;
    end else if (clear_i) begin
      bits_q <= '0;
    end else if (setEn_i) begin
      bits_q[setY_i][setX_i] <= 1'b1;
    end
  end

  assign wasSet_o = bits_q[setY_i][setX_i];
  assign rdData_o = bits_q[rdIdx_i];

endmodule

// File: rtl/point_bitmap_collector.sv
// Collects the rasterizer's interior points into an N x N bitmap for
// one triangle (framed by busy_in), then streams the bitmap out row by
// row over valid/ready and reports the number of distinct points.
// Optional feature macro: POINT_DUP_CHECK_EN enables the sticky
// duplicate-point flag dup_err; without it dup_err is tied low.
module point_bitmap_collector
  import raster_pkg::*;
#(
  parameter int N = RASTER_N
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        busy_in,
  input  logic                        po,
  input  logic [$clog2(N)-1:0]        xo,
  input  logic [$clog2(N)-1:0]        yo,
  output logic                        accept,
  output logic                        row_valid,
  input  logic                        row_ready,
  output logic [$clog2(N)-1:0]        row_idx,
  output logic [N-1:0]                row_data,
  output logic [$clog2(N*N):0]        pt_count,
  output logic                        done,
  output logic                        lost,
  output logic                        dup_err
);

  localparam int CW   = $clog2(N);
  localparam int CntW = $clog2(N * N) + 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(N * N);
  localparam logic [CW-1:0]   LastRow = CW'(N - 1);

  rasterState_e    state_q, state_d;
  logic            busyS_q, busyPrev_q;
  logic [CW-1:0]   rowIdx_q, rowIdx_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] ptCount_q, ptCount_d;
  logic            done_q, done_d;
  logic            lost_q, lost_d;
  logic            memSetEn, memClear, wasSet;
  logic [N-1:0]    rowWord;

  point_bitmap_mem #(
    .N  (N),
    .CW (CW)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .setEn_i  (memSetEn),
    .setX_i   (xo),
    .setY_i   (yo),
    .wasSet_o (wasSet),
    .rdIdx_i  (rowIdx_q),
    .rdData_o (rowWord),
    .clear_i  (memClear)
  );

  // Register busy_in and its previous value; frame edges are judged from these
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busyS_q    <= 1'b0;
      busyPrev_q <= 1'b0;
    end else begin
      busyS_q    <= busy_in;
      busyPrev_q <= busyS_q;
    end
  end

  // State, row pointer, counters and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rowIdx_q  <= '0;
      count_q   <= '0;
      ptCount_q <= '0;
      done_q    <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rowIdx_q  <= rowIdx_d;
      count_q   <= count_d;
      ptCount_q <= ptCount_d;
      done_q    <= done_d;
      lost_q    <= lost_d;
    end
  end

  // Next-state logic: capture in COLLECT, stream rows in DUMP, wrap up on last row
  always_comb begin
    state_d   = state_q;
    rowIdx_d  = rowIdx_q;
    count_d   = count_q;
    ptCount_d = ptCount_q;
    done_d    = 1'b0;
    lost_d    = lost_q;
    memSetEn  = 1'b0;
    memClear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (busyS_q && !busyPrev_q) state_d = COLLECT;
      end
      COLLECT: begin
        if (po) begin
          memSetEn = 1'b1;
          if (!wasSet && (count_q != MaxCnt)) count_d = count_q + CntW'(1);
        end
        if (!busyS_q && busyPrev_q) begin
          state_d  = DUMP;
          rowIdx_d = '0;
        end
      end
      DUMP: begin
        if (po) lost_d = 1'b1;
        if (row_ready) begin
          if (rowIdx_q == LastRow) begin
            ptCount_d = count_q;
            done_d    = 1'b1;
            memClear  = 1'b1;
            count_d   = '0;
            rowIdx_d  = '0;
            state_d   = IDLE;
          end else begin
            rowIdx_d = rowIdx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef POINT_DUP_CHECK_EN
  logic dupErr_q;

  // Sticky flag for a point reported onto an already-set bit during COLLECT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dupErr_q <= 1'b0;
    end else if ((state_q == COLLECT) && po && wasSet) begin
      dupErr_q <= 1'b1;
    end
  end

  assign dup_err = dupErr_q;
`else
  assign dup_err = 1'b0;
`endif

  assign accept    = (state_q != DUMP);
  assign row_valid = (state_q == DUMP);
  assign row_idx   = rowIdx_q;
  assign row_data  = rowWord;
  assign pt_count  = ptCount_q;
  assign done      = done_q;
  assign lost      = lost_q;

endmodule
